// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle between a master and the register-bank slave.
// The master modport drives requests and ready-for-response; the slave modport the rest.
interface axi_lite_reg_slave_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS R/W words with per-register commit pulses.
// Optional macro AXIL_SLVERR_EN: unmapped accesses answer SLVERR instead of OKAY.
module axi_lite_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 12
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    axi_lite_reg_slave_if.slave    s_axi,
    output logic [NUM_REGS*32-1:0] regs_o,
    output logic [NUM_REGS-1:0]    wr_pulse_o
);
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`endif

    typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t         w_state;
    r_state_t         r_state;
    logic [DW-1:0]    regs [NUM_REGS];
    logic             awready, wready, bvalid, arready, rvalid;
    logic [1:0]       bresp, rresp;
    logic [DW-1:0]    rdata;
    logic             aw_done, w_done;
    logic [IDX_W-1:0] aw_idx;
    logic [DW-1:0]    w_data;
    logic [DW/8-1:0]  w_strb;
    logic [IDX_W-1:0] ar_idx;
    logic [DW-1:0]    rd_val;
    logic [1:0]       rd_resp;
    logic             unused_bits;

    function automatic logic is_mapped(input logic [IDX_W-1:0] idx);
        return {{(32-IDX_W){1'b0}}, idx} < NUM_REGS;
    endfunction

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_val,
                                                  input logic [DW-1:0] new_val,
                                                  input logic [DW/8-1:0] strb);
        logic [DW-1:0] m;
        m = old_val;
        for (int i = 0; i < DW/8; i++)
            if (strb[i]) m[8*i +: 8] = new_val[8*i +: 8];
        return m;
    endfunction

    assign s_axi.S_AXI_AWREADY = awready;
    assign s_axi.S_AXI_WREADY  = wready;
    assign s_axi.S_AXI_BVALID  = bvalid;
    assign s_axi.S_AXI_BRESP   = bresp;
    assign s_axi.S_AXI_ARREADY = arready;
    assign s_axi.S_AXI_RVALID  = rvalid;
    assign s_axi.S_AXI_RRESP   = rresp;
    assign s_axi.S_AXI_RDATA   = rdata;

    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
        assign regs_o[32*k +: 32] = regs[k];
    end

    assign ar_idx = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    // Read mux sees pre-commit register values, so a read captured on a commit edge returns old data
    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (ar_idx == IDX_W'(k)) rd_val = regs[k];
`ifdef AXIL_SLVERR_EN
        rd_resp = is_mapped(ar_idx) ? RESP_OKAY : RESP_SLVERR;
`else
        rd_resp = RESP_OKAY;
`endif
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state    <= W_IDLE;
            awready    <= 1'b0;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            bresp      <= RESP_OKAY;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            aw_idx     <= '0;
            w_data     <= '0;
            w_strb     <= '0;
            wr_pulse_o <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            wr_pulse_o <= '0;
            case (w_state)
                W_IDLE, W_COLLECT: begin
                    if (aw_done && w_done) begin
                        for (int k = 0; k < NUM_REGS; k++) begin
                            if (is_mapped(aw_idx) && aw_idx == IDX_W'(k)) begin
                                regs[k]       <= merge_bytes(regs[k], w_data, w_strb);
                                wr_pulse_o[k] <= 1'b1;
                            end
                        end
`ifdef AXIL_SLVERR_EN
                        bresp <= is_mapped(aw_idx) ? RESP_OKAY : RESP_SLVERR;
`else
                        bresp <= RESP_OKAY;
`endif
                        bvalid  <= 1'b1;
                        w_state <= W_RESP;
                    end else begin
                        // Each channel latches independently; its READY stays low until B completes
                        if (awready && s_axi.S_AXI_AWVALID) begin
                            aw_idx  <= s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                            aw_done <= 1'b1;
                            awready <= 1'b0;
                            w_state <= W_COLLECT;
                        end else if (!aw_done) begin
                            awready <= 1'b1;
                        end
                        if (wready && s_axi.S_AXI_WVALID) begin
                            w_data  <= s_axi.S_AXI_WDATA;
                            w_strb  <= s_axi.S_AXI_WSTRB;
                            w_done  <= 1'b1;
                            wready  <= 1'b0;
                            w_state <= W_COLLECT;
                        end else if (!w_done) begin
                            wready <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        bvalid  <= 1'b0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arready && s_axi.S_AXI_ARVALID) begin
                        rdata   <= rd_val;
                        rresp   <= rd_resp;
                        rvalid  <= 1'b1;
                        arready <= 1'b0;
                        r_state <= R_RESP;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_axi.S_AXI_RREADY) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave; expected unmapped response follows AXIL_SLVERR_EN.
module tb_axi_lite_reg_slave;
    localparam int NR  = 12;
    localparam int RVW = NR * 32;
`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
    localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [RVW-1:0] regs_o;
    logic [NR-1:0]  wr_pulse;
    logic [RVW-1:0] snap;
    logic [31:0]    rd;
    logic [1:0]     rr, br;
    logic [NR-1:0]  pl;
    int             checks = 0;
    int             errors = 0;

    always #5 clk = ~clk;

    axi_lite_reg_slave_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    axi_lite_reg_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(6),
        .NUM_REGS(NR)
    ) dut (
        .ACLK(clk),
        .ARESET(rst),
        .s_axi(bus.slave),
        .regs_o(regs_o),
        .wr_pulse_o(wr_pulse)
    );

    task automatic chk(input string tag, input logic [RVW-1:0] obs, input logic [RVW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [NR-1:0] pulse);
        bit aw_pend = 1'b1;
        bit w_pend  = 1'b1;
        bit aw_hs, w_hs;
        int n = 0;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = strb;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = 1'b1;
        while ((aw_pend || w_pend) && n < 20) begin
            aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(negedge clk);
            n++;
            if (aw_hs) begin bus.S_AXI_AWVALID = 1'b0; aw_pend = 1'b0; end
            if (w_hs)  begin bus.S_AXI_WVALID  = 1'b0; w_pend  = 1'b0; end
        end
        chk("wr_hs_timeout", RVW'(aw_pend || w_pend), '0);
        n = 0;
        while (!bus.S_AXI_BVALID && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wr_bvalid_timeout", RVW'(bus.S_AXI_BVALID), RVW'(1));
        resp  = bus.S_AXI_BRESP;
        pulse = wr_pulse;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit ar_pend = 1'b1;
        bit ar_hs;
        int n = 0;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b1;
        while (ar_pend && n < 20) begin
            ar_hs = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
            @(negedge clk);
            n++;
            if (ar_hs) begin bus.S_AXI_ARVALID = 1'b0; ar_pend = 1'b0; end
        end
        chk("rd_ar_timeout", RVW'(ar_pend), '0);
        n = 0;
        while (!bus.S_AXI_RVALID && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rd_rvalid_timeout", RVW'(bus.S_AXI_RVALID), RVW'(1));
        data = bus.S_AXI_RDATA;
        resp = bus.S_AXI_RRESP;
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.S_AXI_AWADDR = '0;  bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA  = '0;  bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0;  bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;

        // Reset state and release
        repeat (20) @(negedge clk);
        chk("rst_awready", RVW'(bus.S_AXI_AWREADY), '0);
        chk("rst_wready",  RVW'(bus.S_AXI_WREADY),  '0);
        chk("rst_arready", RVW'(bus.S_AXI_ARREADY), '0);
        chk("rst_bvalid",  RVW'(bus.S_AXI_BVALID),  '0);
        chk("rst_rvalid",  RVW'(bus.S_AXI_RVALID),  '0);
        chk("rst_resp",    RVW'({bus.S_AXI_BRESP, bus.S_AXI_RRESP}), '0);
        chk("rst_rdata",   RVW'(bus.S_AXI_RDATA),   '0);
        chk("rst_regs",    regs_o, '0);
        chk("rst_pulse",   RVW'(wr_pulse), '0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_readys", RVW'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), RVW'(3'b111));

        // Same-cycle AW/W write to 0x04, cycle-exact response timing
        bus.S_AXI_AWADDR = 6'h04; bus.S_AXI_WDATA = 32'hDEADBEEF; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        chk("t2_readys_low", RVW'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), '0);
        chk("t2_bvalid_early", RVW'(bus.S_AXI_BVALID), '0);
        @(negedge clk);
        chk("t2_bvalid", RVW'(bus.S_AXI_BVALID), RVW'(1));
        chk("t2_bresp",  RVW'(bus.S_AXI_BRESP), '0);
        chk("t2_pulse",  RVW'(wr_pulse), RVW'(12'h002));
        chk("t2_reg1",   RVW'(regs_o[63:32]), RVW'(32'hDEADBEEF));
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        chk("t2_bvalid_clr", RVW'(bus.S_AXI_BVALID), '0);
        chk("t2_readys_back", RVW'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), RVW'(2'b11));
        chk("t2_pulse_clr", RVW'(wr_pulse), '0);
        axi_read(6'h04, rd, rr);
        chk("t2_rdata", RVW'(rd), RVW'(32'hDEADBEEF));
        chk("t2_rresp", RVW'(rr), '0);

        // W three cycles ahead of AW, BREADY held low for five cycles
        bus.S_AXI_WDATA = 32'hA5A5A5A5; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_WVALID = 1'b0;
        chk("t3_wready_low", RVW'(bus.S_AXI_WREADY), '0);
        chk("t3_awready_hi", RVW'(bus.S_AXI_AWREADY), RVW'(1));
        repeat (2) @(negedge clk);
        chk("t3_wready_still_low", RVW'(bus.S_AXI_WREADY), '0);
        bus.S_AXI_AWADDR = 6'h0C; bus.S_AXI_AWVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0;
        chk("t3_bvalid_early", RVW'(bus.S_AXI_BVALID), '0);
        @(negedge clk);
        chk("t3_bvalid", RVW'(bus.S_AXI_BVALID), RVW'(1));
        chk("t3_pulse",  RVW'(wr_pulse), RVW'(12'h008));
        chk("t3_reg3",   RVW'(regs_o[127:96]), RVW'(32'hA5A5A5A5));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_bvalid_hold", RVW'(bus.S_AXI_BVALID), RVW'(1));
            chk("t3_bresp_hold",  RVW'(bus.S_AXI_BRESP), '0);
            chk("t3_readys_hold", RVW'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), '0);
            chk("t3_pulse_once",  RVW'(wr_pulse), '0);
        end
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0;
        chk("t3_bvalid_clr", RVW'(bus.S_AXI_BVALID), '0);
        chk("t3_awready_back", RVW'(bus.S_AXI_AWREADY), RVW'(1));

        // Partial strobes over an all-ones word
        axi_write(6'h08, 32'hFFFFFFFF, 4'hF, br, pl);
        chk("t4_bresp_full", RVW'(br), '0);
        axi_write(6'h08, 32'h11223344, 4'b0101, br, pl);
        chk("t4_bresp", RVW'(br), '0);
        chk("t4_pulse", RVW'(pl), RVW'(12'h004));
        axi_read(6'h08, rd, rr);
        chk("t4_rdata", RVW'(rd), RVW'(32'hFF22FF44));

        // Empty strobe still pulses, changes nothing
        axi_write(6'h04, 32'h00000000, 4'b0000, br, pl);
        chk("strb0_bresp", RVW'(br), '0);
        chk("strb0_pulse", RVW'(pl), RVW'(12'h002));
        chk("strb0_reg1",  RVW'(regs_o[63:32]), RVW'(32'hDEADBEEF));

        // Read captured on the commit edge of a write to the same register
        bus.S_AXI_AWADDR = 6'h08; bus.S_AXI_WDATA = 32'h0; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_ARADDR = 6'h08; bus.S_AXI_ARVALID = 1'b1;
        chk("t5_arready", RVW'(bus.S_AXI_ARREADY), RVW'(1));
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        chk("t5_rvalid",   RVW'(bus.S_AXI_RVALID), RVW'(1));
        chk("t5_rdata_old", RVW'(bus.S_AXI_RDATA), RVW'(32'hFF22FF44));
        chk("t5_bvalid",   RVW'(bus.S_AXI_BVALID), RVW'(1));
        chk("t5_reg2_new", RVW'(regs_o[95:64]), '0);
        @(negedge clk);
        chk("t5_rdata_stable", RVW'(bus.S_AXI_RDATA), RVW'(32'hFF22FF44));
        chk("t5_rvalid_hold", RVW'(bus.S_AXI_RVALID), RVW'(1));
        bus.S_AXI_RREADY = 1'b1; bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;
        chk("t5_valids_clr", RVW'({bus.S_AXI_RVALID, bus.S_AXI_BVALID}), '0);
        axi_read(6'h08, rd, rr);
        chk("t5_rdata_new", RVW'(rd), '0);

        // Last mapped slot, then the first unmapped one
        axi_write(6'h2C, 32'hCAFEF00D, 4'hF, br, pl);
        chk("t6_last_pulse", RVW'(pl), RVW'(12'h800));
        axi_read(6'h2C, rd, rr);
        chk("t6_last_rdata", RVW'(rd), RVW'(32'hCAFEF00D));
        snap = regs_o;
        axi_write(6'h30, 32'h12345678, 4'hF, br, pl);
        chk("t6_unmap_bresp", RVW'(br), RVW'(UNMAP_RESP));
        chk("t6_unmap_pulse", RVW'(pl), '0);
        chk("t6_unmap_regs",  regs_o, snap);
        axi_read(6'h30, rd, rr);
        chk("t6_unmap_rdata", RVW'(rd), '0);
        chk("t6_unmap_rresp", RVW'(rr), RVW'(UNMAP_RESP));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
